// File: rtl/nonogram_pkg.sv
// Shared types and constants for the nonogram option store.
// Holds the store FSM state type, line-table geometry and the line-table
// entry layout used by option_store_ctrl.
package nonogram_pkg;

  localparam int unsigned MAX_LINES  = 22;  // rows + columns of an 11x11 board
  localparam int unsigned OPT_CNT_W  = 7;
  localparam int unsigned LINE_IDX_W = 5;
  localparam int unsigned BASE_W     = 16;  // widest supported BRAM address

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_READY   = 2'd2,
    ST_RD_WAIT = 2'd3
  } store_state_t;

  typedef struct packed {
    logic [BASE_W-1:0]    base;
    logic [OPT_CNT_W-1:0] count;
  } line_entry_t;

endpackage

// File: rtl/option_bram.sv
// Single-port option RAM, DATA_W x 2**ADDR_W, registered read output.
// Ports: clk; we/addr/wdata write port; rdata holds mem[addr] sampled at
// the previous edge (read-before-write on the same address).
module option_bram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/option_store_ctrl.sv
// Option store controller: builds a per-line table (base, count) while the
// parser streams header/option words into the option BRAM, then serves
// (line, option#) reads for the solver with a fixed 2-edge latency.
// Ports: clk, rst (async, active high); board_start/board_done framing;
// in_valid/in_hdr/in_data parser stream; rd_req/rd_line/rd_opt requests;
// rd_ready/rd_valid/rd_data/rd_count/rd_miss responses; solver_start,
// lines_loaded, busy status; err_orphan/err_overflow sticky errors.
// Build option: OPTION_STORE_OVERFLOW_CHECK_EN stops writes once the last
// BRAM location is used and raises err_overflow; otherwise wr_addr wraps.
module option_store_ctrl #(
  parameter int unsigned MAX_LINES = nonogram_pkg::MAX_LINES,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              board_start,
  input  logic              in_valid,
  input  logic              in_hdr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              board_done,
  input  logic              rd_req,
  input  logic [4:0]        rd_line,
  input  logic [6:0]        rd_opt,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [6:0]        rd_count,
  output logic              rd_miss,
  output logic              solver_start,
  output logic [4:0]        lines_loaded,
  output logic              busy,
  output logic              err_orphan,
  output logic              err_overflow
);

  import nonogram_pkg::*;

  store_state_t          state;
  line_entry_t           tbl [MAX_LINES];
  logic [ADDR_W-1:0]     wr_addr;
  logic [LINE_IDX_W-1:0] cur_line;
  logic                  cur_valid;
  logic                  rd_phase;
  logic                  rd_miss_q;
  logic [OPT_CNT_W-1:0]  rd_count_q;

  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  logic [LINE_IDX_W-1:0] hdr_idx;
  logic                  hdr_ok;
  logic [OPT_CNT_W-1:0]  cur_count;
  logic                  lookup_hit;
  logic [OPT_CNT_W-1:0]  lookup_count;
  logic [BASE_W-1:0]     lookup_base;

`ifdef OPTION_STORE_OVERFLOW_CHECK_EN
  logic full;
`endif

  option_bram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bram (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  assign rd_ready = (state == ST_READY);
  assign busy     = (state == ST_LOAD) || (state == ST_RD_WAIT);

  always_comb begin
    hdr_idx      = in_data[LINE_IDX_W-1:0];
    hdr_ok       = 32'(hdr_idx) < MAX_LINES;
    cur_count    = '0;
    if (32'(cur_line) < MAX_LINES) cur_count = tbl[cur_line].count;
    lookup_hit   = 32'(rd_line) < MAX_LINES;
    lookup_count = '0;
    lookup_base  = '0;
    if (lookup_hit) begin
      lookup_count = tbl[rd_line].count;
      lookup_base  = tbl[rd_line].base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      wr_addr      <= '0;
      cur_line     <= '0;
      cur_valid    <= 1'b0;
      lines_loaded <= '0;
      err_orphan   <= 1'b0;
      for (int unsigned i = 0; i < MAX_LINES; i++) tbl[i] <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rd_phase     <= 1'b0;
      rd_miss_q    <= 1'b0;
      rd_count_q   <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_count     <= '0;
      rd_miss      <= 1'b0;
      solver_start <= 1'b0;
`ifdef OPTION_STORE_OVERFLOW_CHECK_EN
      full         <= 1'b0;
      err_overflow <= 1'b0;
`endif
    end else begin
      mem_we       <= 1'b0;
      rd_valid     <= 1'b0;
      solver_start <= 1'b0;
      if (board_start) begin
        state        <= ST_LOAD;
        wr_addr      <= '0;
        cur_valid    <= 1'b0;
        lines_loaded <= '0;
        err_orphan   <= 1'b0;
        rd_phase     <= 1'b0;
        for (int unsigned i = 0; i < MAX_LINES; i++) tbl[i] <= '0;
`ifdef OPTION_STORE_OVERFLOW_CHECK_EN
        full         <= 1'b0;
        err_overflow <= 1'b0;
`endif
      end else begin
        case (state)
          // IDLE is only reachable through reset, so the table is already
          // clear and a header can be handled exactly as in LOAD.
          ST_IDLE, ST_LOAD: begin
            if (in_valid && in_hdr) begin
              if (hdr_ok) begin
                tbl[hdr_idx].base  <= BASE_W'(wr_addr);
                tbl[hdr_idx].count <= '0;
                cur_line           <= hdr_idx;
                cur_valid          <= 1'b1;
                if (lines_loaded != '1) lines_loaded <= lines_loaded + 5'd1;
              end else begin
                err_orphan <= 1'b1;
                cur_valid  <= 1'b0;
              end
              state <= ST_LOAD;
            end else if (in_valid) begin
              if (state == ST_IDLE || !cur_valid) begin
                err_orphan <= 1'b1;
`ifdef OPTION_STORE_OVERFLOW_CHECK_EN
              end else if (full) begin
                err_overflow <= 1'b1;
`endif
              end else begin
                // A word past a saturated count still consumes storage so
                // wr_addr tracks total traffic; it is unreachable by reads.
                mem_we    <= 1'b1;
                mem_addr  <= wr_addr;
                mem_wdata <= in_data;
                wr_addr   <= wr_addr + 1'b1;
                if (cur_count == '1) err_orphan <= 1'b1;
                else tbl[cur_line].count <= cur_count + 1'b1;
`ifdef OPTION_STORE_OVERFLOW_CHECK_EN
                if (wr_addr == '1) full <= 1'b1;
`endif
              end
            end
            if (board_done) begin
              state        <= ST_READY;
              solver_start <= 1'b1;
            end
          end
          ST_READY: begin
            if (in_valid) err_orphan <= 1'b1;
            if (rd_req) begin
              mem_addr   <= ADDR_W'(lookup_base + BASE_W'(rd_opt));
              rd_count_q <= lookup_count;
              rd_miss_q  <= !lookup_hit || (rd_opt >= lookup_count);
              rd_phase   <= 1'b0;
              state      <= ST_RD_WAIT;
            end
          end
          ST_RD_WAIT: begin
            if (in_valid) err_orphan <= 1'b1;
            // phase 0: BRAM samples the address; phase 1: its output is valid
            if (!rd_phase) begin
              rd_phase <= 1'b1;
            end else begin
              rd_phase <= 1'b0;
              rd_valid <= 1'b1;
              rd_data  <= rd_miss_q ? '0 : mem_rdata;
              rd_count <= rd_count_q;
              rd_miss  <= rd_miss_q;
              state    <= ST_READY;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifndef OPTION_STORE_OVERFLOW_CHECK_EN
  assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_option_store_ctrl.sv
module tb_option_store_ctrl;
  import nonogram_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        board_start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_hdr = 1'b0;
  logic [15:0] in_data = '0;
  logic        board_done = 1'b0;
  logic        rd_req = 1'b0;
  logic [4:0]  rd_line = '0;
  logic [6:0]  rd_opt = '0;
  logic        rd_ready, rd_valid, rd_miss, solver_start, busy;
  logic        err_orphan, err_overflow;
  logic [15:0] rd_data;
  logic [6:0]  rd_count;
  logic [4:0]  lines_loaded;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] data;
    logic [6:0]  count;
    logic        miss;
  } exp_t;
  exp_t exp_q[$];

  option_store_ctrl dut (
    .clk(clk), .rst(rst), .board_start(board_start), .in_valid(in_valid),
    .in_hdr(in_hdr), .in_data(in_data), .board_done(board_done),
    .rd_req(rd_req), .rd_line(rd_line), .rd_opt(rd_opt),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_count(rd_count), .rd_miss(rd_miss), .solver_start(solver_start),
    .lines_loaded(lines_loaded), .busy(busy), .err_orphan(err_orphan),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic hdr, input logic [15:0] d, input logic done);
    in_valid = 1'b1; in_hdr = hdr; in_data = d; board_done = done;
    step();
    in_valid = 1'b0; in_hdr = 1'b0; board_done = 1'b0;
  endtask

  task automatic pulse_start();
    board_start = 1'b1;
    step();
    board_start = 1'b0;
  endtask

  task automatic pulse_done();
    board_done = 1'b1;
    step();
    board_done = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!rd_ready && n < 20) begin
      step();
      n++;
    end
    if (!rd_ready) chk("rd_ready_timeout", 32'(rd_ready), 32'd1);
  endtask

  // Issue one read; expected response goes to the scoreboard and the
  // fixed acceptance+2 latency is checked here.
  task automatic do_read(input logic [4:0] line, input logic [6:0] opt,
                         input logic [15:0] d, input logic [6:0] c, input logic m);
    exp_t e;
    wait_ready();
    e.data = d; e.count = c; e.miss = m;
    exp_q.push_back(e);
    rd_req = 1'b1; rd_line = line; rd_opt = opt;
    step();
    rd_req = 1'b0;
    chk("rd_ready_low_k1", 32'(rd_ready), 32'd0);
    chk("rd_valid_early_k1", 32'(rd_valid), 32'd0);
    step();
    chk("rd_ready_low_k2", 32'(rd_ready), 32'd0);
    chk("rd_valid_early_k2", 32'(rd_valid), 32'd0);
    step();
    chk("rd_valid_latency", 32'(rd_valid), 32'd1);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.data));
        chk("rd_count", 32'(rd_count), 32'(e.count));
        chk("rd_miss", 32'(rd_miss), 32'(e.miss));
      end
    end
  end

  initial begin
    logic [15:0] w0_exp;
    repeat (3) step();
    chk("rst_rd_ready", 32'(rd_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lines", 32'(lines_loaded), 32'd0);
    chk("rst_err_orphan", 32'(err_orphan), 32'd0);
    chk("rst_err_overflow", 32'(err_overflow), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_state", 32'(dut.state), 32'(ST_IDLE));

    // basic board
    pulse_start();
    chk("load_busy", 32'(busy), 32'd1);
    word(1'b1, 16'd0, 1'b0);
    word(1'b0, 16'h0003, 1'b0);
    word(1'b0, 16'h0006, 1'b0);
    word(1'b1, 16'd1, 1'b0);
    word(1'b0, 16'h0005, 1'b0);
    pulse_done();
    chk("solver_start", 32'(solver_start), 32'd1);
    chk("ready_with_start", 32'(rd_ready), 32'd1);
    chk("lines_loaded_2", 32'(lines_loaded), 32'd2);
    step();
    chk("solver_start_pulse", 32'(solver_start), 32'd0);
    do_read(5'd1, 7'd0, 16'h0005, 7'd1, 1'b0);
    do_read(5'd0, 7'd1, 16'h0006, 7'd2, 1'b0);
    do_read(5'd0, 7'd0, 16'h0003, 7'd2, 1'b0);
    do_read(5'd0, 7'd2, 16'h0000, 7'd2, 1'b1);
    do_read(5'd7, 7'd0, 16'h0000, 7'd0, 1'b1);
    do_read(5'd25, 7'd0, 16'h0000, 7'd0, 1'b1);

    // orphan words
    pulse_start();
    chk("start_clears_orphan", 32'(err_orphan), 32'd0);
    word(1'b0, 16'h0001, 1'b0);
    chk("orphan_no_header", 32'(err_orphan), 32'd1);
    chk("orphan_wr_addr", 32'(dut.wr_addr), 32'd0);
    word(1'b1, 16'd25, 1'b0);
    chk("orphan_hdr25_addr", 32'(dut.wr_addr), 32'd0);
    chk("orphan_hdr25_lines", 32'(lines_loaded), 32'd0);

    // re-header, and board_done together with the last word
    pulse_start();
    word(1'b1, 16'd2, 1'b0);
    word(1'b0, 16'h00AA, 1'b0);
    word(1'b1, 16'd2, 1'b0);
    word(1'b0, 16'h00BB, 1'b0);
    word(1'b1, 16'd3, 1'b0);
    word(1'b0, 16'h0011, 1'b0);
    word(1'b0, 16'h0009, 1'b1);
    chk("done_with_word_start", 32'(solver_start), 32'd1);
    chk("lines_loaded_3", 32'(lines_loaded), 32'd3);
    do_read(5'd3, 7'd1, 16'h0009, 7'd2, 1'b0);
    do_read(5'd2, 7'd0, 16'h00BB, 7'd1, 1'b0);
    do_read(5'd2, 7'd1, 16'h0000, 7'd1, 1'b1);

    // abort in RD_WAIT
    word(1'b0, 16'h1234, 1'b0);
    chk("ready_word_orphan", 32'(err_orphan), 32'd1);
    wait_ready();
    rd_req = 1'b1; rd_line = 5'd3; rd_opt = 7'd0;
    step();
    rd_req = 1'b0;
    pulse_start();
    chk("abort_state", 32'(dut.state), 32'(ST_LOAD));
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_flags", 32'({err_orphan, err_overflow}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_rd_valid", 32'(rd_valid), 32'd0);
      step();
    end

    // 1025 words under one header
    word(1'b1, 16'd0, 1'b0);
    in_valid = 1'b1; in_hdr = 1'b0;
    for (int i = 0; i < 1025; i++) begin
      in_data = 16'h4000 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    pulse_done();
    chk("ovf_err_orphan", 32'(err_orphan), 32'd1);
    chk("ovf_lines", 32'(lines_loaded), 32'd1);
`ifdef OPTION_STORE_OVERFLOW_CHECK_EN
    chk("ovf_err_overflow", 32'(err_overflow), 32'd1);
    w0_exp = 16'h4000;
`else
    chk("ovf_err_overflow", 32'(err_overflow), 32'd0);
    w0_exp = 16'h4400;
`endif
    do_read(5'd0, 7'd0, w0_exp, 7'd127, 1'b0);
    do_read(5'd0, 7'd126, 16'h407E, 7'd127, 1'b0);
    do_read(5'd0, 7'd127, 16'h0000, 7'd127, 1'b1);

    repeat (4) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
